// File: rtl/elixirchip_es1_spu_shift_pkg.sv
// Shared types and elaboration helpers for the SIMD shift unit.
package elixirchip_es1_spu_shift_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_t;

  function automatic int calc_shift_bits(input int max_shift);
    return $clog2(max_shift + 1);
  endfunction

  function automatic int calc_lane_count(input int bus_bits, input int data_bits);
    return bus_bits / data_bits;
  endfunction

  function automatic int calc_bits_per_stage(input int shift_bits, input int latency);
    return (shift_bits + latency - 1) / latency;
  endfunction

  // Shift-amount bits are grouped LSB first; group g is applied in pipeline stage g.
  function automatic int stage_of_bit(input int bit_index, input int shift_bits, input int latency);
    return bit_index / calc_bits_per_stage(shift_bits, latency);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_shift_lane.sv
// One lane of the staged barrel shifter; the carry travels with the data as an extra bit.
module elixirchip_es1_spu_shift_lane
  import elixirchip_es1_spu_shift_pkg::*;
#(
  parameter int                   LATENCY    = 1,
  parameter int                   DATA_BITS  = 8,
  parameter int                   MAX_SHIFT  = DATA_BITS,
  parameter int                   SHIFT_BITS = calc_shift_bits(MAX_SHIFT),
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cke,
  input  logic [LATENCY*3-1:0]            stage_mode,
  input  logic [LATENCY*SHIFT_BITS-1:0]   stage_shift,
  input  logic [DATA_BITS-1:0]            s_data,
  input  logic                            out_valid,
  input  logic                            out_clear,
  output logic [DATA_BITS-1:0]            m_data,
  output logic                            m_carry
);

  localparam int W = DATA_BITS + 1;

  // Vector layout is {carry, data}. Logical/arithmetic shifts act on the full
  // W-bit vector so the carry bit ends up holding the last bit shifted out.
  function automatic logic [W-1:0] shift_step(
    input logic [W-1:0]            v,
    input logic [2:0]              mode,
    input logic [SHIFT_BITS-1:0]   sh,
    input int                      stage
  );
    logic [W-1:0]           r;
    logic [W-1:0]           t;
    logic [2*DATA_BITS-1:0] rot;
    int                     amt;
    r = v;
    for (int j = 0; j < SHIFT_BITS; j++) begin
      if (stage_of_bit(j, SHIFT_BITS, LATENCY) == stage && sh[j]) begin
        amt = 1 << j;
        case (shift_mode_t'(mode))
          SLL: r = r << amt;
          SRL: begin
            t = {r[DATA_BITS-1:0], r[DATA_BITS]} >> amt;
            r = {t[0], t[W-1:1]};
          end
          SRA: begin
            t = $signed({r[DATA_BITS-1:0], r[DATA_BITS]}) >>> amt;
            r = {t[0], t[W-1:1]};
          end
          ROL: begin
            rot = {r[DATA_BITS-1:0], r[DATA_BITS-1:0]} << (amt % DATA_BITS);
            r   = {1'b0, rot[2*DATA_BITS-1:DATA_BITS]};
          end
          ROR: begin
            rot = {r[DATA_BITS-1:0], r[DATA_BITS-1:0]} >> (amt % DATA_BITS);
            r   = {1'b0, rot[DATA_BITS-1:0]};
          end
          default: r = v;
        endcase
      end
    end
    return r;
  endfunction

  logic [LATENCY*W-1:0] dat_vec;
  logic [W-1:0]         stage_out [LATENCY];
  logic [2:0]           last_mode;
  logic [SHIFT_BITS-1:0] last_shift;
  logic                 zero_result;

  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      stage_out[k] = shift_step(dat_vec[k*W +: W], stage_mode[k*3 +: 3],
                                stage_shift[k*SHIFT_BITS +: SHIFT_BITS], k);
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [(LATENCY-1)*W-1:0] dat_q;
      assign dat_vec = {dat_q, 1'b0, s_data};
      // NOTE: intermediate data stages are not reset; the control pipeline's
      // cleared valid flags already keep stale contents from reaching m_data.
      always_ff @(posedge clk) begin
        if (cke) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            dat_q[k*W +: W] <= stage_out[k];
          end
        end
      end
    end else begin : g_no_pipe
      assign dat_vec = {1'b0, s_data};
    end
  endgenerate

  assign last_mode   = stage_mode[(LATENCY-1)*3 +: 3];
  assign last_shift  = stage_shift[(LATENCY-1)*SHIFT_BITS +: SHIFT_BITS];
  assign zero_result = (last_mode > ROR) || (32'(last_shift) > MAX_SHIFT);

  // NOTE: every register is written with <= so all stages sample the
  // pre-edge values and the pipeline advances in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data  <= CLEAR_DATA;
      m_carry <= 1'b0;
    end else if (cke) begin
      if (out_clear) begin
        m_data  <= CLEAR_DATA;
        m_carry <= 1'b0;
      end else if (out_valid) begin
        if (zero_result) begin
          m_data  <= '0;
          m_carry <= 1'b0;
        end else begin
          {m_carry, m_data} <= stage_out[LATENCY-1];
        end
      end
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_shift.sv
// SIMD shift/rotate unit: shared control pipeline feeding LANES staged lane shifters.
module elixirchip_es1_spu_op_shift
  import elixirchip_es1_spu_shift_pkg::*;
#(
  parameter int                   LATENCY         = 1,
  parameter int                   DATA_BITS       = 8,
  parameter int                   LANES           = 1,
  parameter int                   MAX_SHIFT       = DATA_BITS,
  parameter int                   SHIFT_BITS      = calc_shift_bits(MAX_SHIFT),
  parameter logic [DATA_BITS-1:0] CLEAR_DATA      = '1,
  parameter bit                   IMMEDIATE_SHIFT = 1'b0,
  parameter bit                   IMMEDIATE_DATA  = 1'b0,
  parameter bit                   IMMEDIATE_MODE  = 1'b0,
  parameter string                DEVICE          = "RTL",
  parameter string                SIMULATION      = "false",
  parameter string                DEBUG           = "false"
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cke,
  input  logic [2:0]                   s_mode,
  input  logic [SHIFT_BITS-1:0]        s_shift,
  input  logic [LANES*DATA_BITS-1:0]   s_data,
  input  logic                         s_clear,
  input  logic                         s_valid,
  output logic [LANES*DATA_BITS-1:0]   m_data,
  output logic [LANES-1:0]             m_carry,
  output logic                         m_valid
);

  // Control word per stage: {valid, clear, mode, shift}.
  localparam int CW = 5 + SHIFT_BITS;

  logic [CW-1:0]                 ctl_in;
  logic [LATENCY*CW-1:0]         ctl_vec;
  logic [LATENCY*3-1:0]          stage_mode;
  logic [LATENCY*SHIFT_BITS-1:0] stage_shift;
  logic                          out_valid;
  logic                          out_clear;

  assign ctl_in = {s_valid, s_clear, s_mode, s_shift};

  generate
    if (LATENCY > 1) begin : g_ctl
      logic [(LATENCY-1)*CW-1:0] ctl_q;
      assign ctl_vec = {ctl_q, ctl_in};
      always_ff @(posedge clk) begin
        if (reset) begin
          ctl_q <= '0;
        end else if (cke) begin
          ctl_q <= ctl_vec[(LATENCY-1)*CW-1:0];
        end
      end
    end else begin : g_no_ctl
      assign ctl_vec = ctl_in;
    end
  endgenerate

  // Constant operands bypass their pipeline copies so synthesis can drop them.
  always_comb begin
    stage_mode  = '0;
    stage_shift = '0;
    for (int k = 0; k < LATENCY; k++) begin
      stage_mode[k*3 +: 3] = IMMEDIATE_MODE ? s_mode
                                            : ctl_vec[k*CW + SHIFT_BITS +: 3];
      stage_shift[k*SHIFT_BITS +: SHIFT_BITS] = IMMEDIATE_SHIFT ? s_shift
                                                                : ctl_vec[k*CW +: SHIFT_BITS];
    end
  end

  assign out_valid = ctl_vec[LATENCY*CW-1];
  assign out_clear = ctl_vec[LATENCY*CW-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
    end else if (cke) begin
      m_valid <= out_valid & ~out_clear;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      elixirchip_es1_spu_shift_lane #(
        .LATENCY    (LATENCY),
        .DATA_BITS  (DATA_BITS),
        .MAX_SHIFT  (MAX_SHIFT),
        .SHIFT_BITS (SHIFT_BITS),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .stage_mode  (stage_mode),
        .stage_shift (stage_shift),
        .s_data      (s_data[i*DATA_BITS +: DATA_BITS]),
        .out_valid   (out_valid),
        .out_clear   (out_clear),
        .m_data      (m_data[i*DATA_BITS +: DATA_BITS]),
        .m_carry     (m_carry[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_shift.sv
// Directed bench: two 8-bit lanes, three pipeline stages, expected values worked by hand.
module tb_elixirchip_es1_spu_op_shift;
  import elixirchip_es1_spu_shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [2:0]  s_mode;
  logic [3:0]  s_shift;
  logic [15:0] s_data;
  logic        s_clear;
  logic        s_valid;
  logic [15:0] m_data;
  logic [1:0]  m_carry;
  logic        m_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_shift #(
    .LATENCY    (3),
    .DATA_BITS  (8),
    .LANES      (2),
    .MAX_SHIFT  (15),
    .CLEAR_DATA (8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .s_mode  (s_mode),
    .s_shift (s_shift),
    .s_data  (s_data),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .m_data  (m_data),
    .m_carry (m_carry),
    .m_valid (m_valid)
  );

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic [1:0] c, input logic v);
    check({tag, "/data"},  m_data,             d);
    check({tag, "/carry"}, {14'b0, m_carry},   {14'b0, c});
    check({tag, "/valid"}, {15'b0, m_valid},   {15'b0, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid beat, then idle until the result reaches the output stage.
  task automatic op(input logic [2:0] mode, input logic [3:0] sh, input logic [15:0] d);
    s_mode  = mode;
    s_shift = sh;
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_mode  = SLL;
    s_shift = 4'd0;
    s_data  = 16'h0000;
    s_clear = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    expect_out("reset", 16'hFFFF, 2'b00, 1'b0);
    reset = 1'b0;

    op(SRL, 4'd4, 16'h81F0);
    expect_out("srl4", 16'h080F, 2'b00, 1'b1);
    tick();
    expect_out("srl4_hold", 16'h080F, 2'b00, 1'b0);

    op(SRA, 4'd3, 16'h4080);
    expect_out("sra3", 16'h08F0, 2'b00, 1'b1);
    op(SRA, 4'd8, 16'h4080);
    expect_out("sra8", 16'h00FF, 2'b01, 1'b1);
    op(SLL, 4'd8, 16'h8001);
    expect_out("sll8", 16'h0000, 2'b01, 1'b1);
    op(ROL, 4'd9, 16'h1081);
    expect_out("rol9", 16'h2003, 2'b00, 1'b1);
    op(ROR, 4'd1, 16'h0201);
    expect_out("ror1", 16'h0180, 2'b00, 1'b1);
    op(SRL, 4'd4, 16'h1808);
    expect_out("srl_carry", 16'h0100, 2'b11, 1'b1);
    op(SLL, 4'd0, 16'h5AA5);
    expect_out("sll0", 16'h5AA5, 2'b00, 1'b1);
    op(SRL, 4'd9, 16'hFFFF);
    expect_out("srl9", 16'h0000, 2'b00, 1'b1);
    op(SRA, 4'd12, 16'h7F80);
    expect_out("sra12", 16'h00FF, 2'b01, 1'b1);
    op(3'd5, 4'd3, 16'h1234);
    expect_out("reserved", 16'h0000, 2'b00, 1'b1);
    op(ROR, 4'd15, 16'h8001);
    expect_out("ror15", 16'h0102, 2'b00, 1'b1);

    // Clear wins over valid; a following idle beat leaves the cleared value.
    s_mode  = SLL;
    s_shift = 4'd0;
    s_data  = 16'h1234;
    s_clear = 1'b1;
    s_valid = 1'b1;
    tick();
    s_clear = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    expect_out("clear", 16'hFFFF, 2'b00, 1'b0);
    tick();
    expect_out("clear_hold", 16'hFFFF, 2'b00, 1'b0);

    // Two ops in flight, clock enable dropped for three cycles.
    s_mode = SLL; s_shift = 4'd1; s_data = 16'h0102; s_valid = 1'b1;
    tick();
    s_mode = SRL; s_shift = 4'd1; s_data = 16'h0303;
    tick();
    cke = 1'b0;
    s_mode = SLL; s_shift = 4'd2; s_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze/data",  m_data,          16'hFFFF);
      check("freeze/valid", {15'b0, m_valid}, 16'h0000);
    end
    s_valid = 1'b0;
    cke     = 1'b1;
    tick();
    expect_out("resume_a", 16'h0204, 2'b00, 1'b1);
    tick();
    expect_out("resume_b", 16'h0101, 2'b11, 1'b1);
    tick();
    expect_out("resume_idle", 16'h0101, 2'b11, 1'b0);
    tick();
    expect_out("resume_idle2", 16'h0101, 2'b11, 1'b0);

    // Reset (with clock enable low) while two ops are in flight.
    s_mode = SLL; s_shift = 4'd1; s_data = 16'h0101; s_valid = 1'b1;
    tick();
    s_mode = SRL; s_shift = 4'd1; s_data = 16'h8080;
    tick();
    s_valid = 1'b0;
    reset   = 1'b1;
    cke     = 1'b0;
    tick();
    expect_out("rst_flight", 16'hFFFF, 2'b00, 1'b0);
    reset = 1'b0;
    cke   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_drain/data",  m_data,          16'hFFFF);
      check("rst_drain/valid", {15'b0, m_valid}, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_shift.md
ELIXIRCHIP_ES1_SPU_OP_SHIFT -- requirements
Module: elixirchip_es1_spu_op_shift

Interface
- REQ-001 The module SHALL have parameter LATENCY, default 1, meaning the number of cke-qualified pipeline stages, legal range 1..4.
- REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning the width of one lane.
- REQ-003 The module SHALL have parameter LANES, default 1, meaning the number of independent SIMD lanes.
- REQ-004 The module SHALL have parameter MAX_SHIFT, default DATA_BITS, meaning the largest legal shift amount.
- REQ-005 The module SHALL have parameter SHIFT_BITS, default $clog2(MAX_SHIFT+1), meaning the shift amount width.
- REQ-006 The module SHALL have parameter CLEAR_DATA, default all ones, DATA_BITS wide, meaning the per-lane clear/reset value.
- REQ-007 The module SHALL have parameters IMMEDIATE_SHIFT=0, IMMEDIATE_DATA=0, IMMEDIATE_MODE=0, meaning the input is constant, which permits omitting its pipeline registers.
- REQ-008 The module SHALL have parameters DEVICE="RTL", SIMULATION="false", DEBUG="false", which are passed through only.
- REQ-009 The module SHALL have port clk, input, 1 bit: the clock.
- REQ-010 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
- REQ-011 The module SHALL have port cke, input, 1 bit: the clock enable for all state.
- REQ-012 The module SHALL have port s_mode, input, 3 bits: the operation selector (SLL, SRL, SRA, ROL, ROR).
- REQ-013 The module SHALL have port s_shift, input, SHIFT_BITS wide: the shift amount, shared by all lanes.
- REQ-014 The module SHALL have port s_data, input, LANES*DATA_BITS wide: the operand, with lane i at bits [i*DATA_BITS +: DATA_BITS].
- REQ-015 The module SHALL have ports s_clear and s_valid, inputs, 1 bit each: clear request and data-valid.
- REQ-016 The module SHALL have port m_data, output, LANES*DATA_BITS wide: the result.
- REQ-017 The module SHALL have port m_carry, output, LANES bits: the last bit shifted out, per lane.
- REQ-018 The module SHALL have port m_valid, output, 1 bit: set when m_data was updated by a valid operation.

Function
- REQ-019 The module SHALL update all pipeline state only on posedge clk with cke=1; with cke=0 every stage and output holds its value.
- REQ-020 The module SHALL present the effect of inputs sampled at one cke-qualified edge on its outputs exactly LATENCY cke-qualified edges later.
- REQ-021 The module SHALL give s_clear priority at the output stage: m_data = CLEAR_DATA in every lane, m_carry=0, m_valid=0.
- REQ-022 When s_valid=1 and s_clear=0, the module SHALL load m_data and m_carry with the result and set m_valid=1.
- REQ-023 When s_valid=0 and s_clear=0, the module SHALL hold m_data and m_carry and set m_valid=0.
- REQ-024 SLL/SRL SHALL zero-fill; SRA SHALL fill with the lane MSB; lanes SHALL never exchange bits.
- REQ-025 For SLL/SRL/SRA with shift >= DATA_BITS, the module SHALL output a fully filled result (0 for logical shifts, sign for SRA).
- REQ-026 For ROL/ROR, the module SHALL apply shift modulo DATA_BITS.
- REQ-027 For shifts of 1..DATA_BITS, m_carry SHALL be the last bit shifted out (SRA beyond DATA_BITS: the sign).
- REQ-028 m_carry SHALL be 0 for shift 0, for logical shifts > DATA_BITS, and for rotates.
- REQ-029 Shift amounts above MAX_SHIFT and reserved s_mode codes SHALL produce a result of 0 with m_carry=0.
- REQ-030 When multiple stages are present, the module SHALL split the barrel shifter across stages by shift-amount bit, LSB group first.

Reset
- REQ-031 While reset=1, regardless of cke, the module SHALL clear all internal valid and clear flags, set m_data = CLEAR_DATA per lane, and set m_carry=0 and m_valid=0.
- REQ-032 Operations in flight when reset asserts SHALL be discarded; no output SHALL reflect them after reset.

Structure
- REQ-033 Package elixirchip_es1_spu_shift_pkg SHALL hold the shift_mode_t enum (SLL=0, SRL=1, SRA=2, ROL=3, ROR=4) and the lane-count and shift-width helper functions.
- REQ-034 Sub-module elixirchip_es1_spu_shift_lane SHALL implement one lane's staged shifter; the top SHALL instantiate it LANES times and own the control pipeline.

Verification (DATA_BITS=8, LANES=2, CLEAR_DATA=8'hFF, cke=1 unless stated)
- REQ-035 The bench SHALL check: SRL, lane0 8'hF0, lane1 8'h81, shift 4 -> m_data {8'h08, 8'h0F}, m_carry 2'b00, m_valid=1 after LATENCY edges.
- REQ-036 The bench SHALL check: SRA 8'h80 with shift 3 -> 8'hF0; with shift 8 -> 8'hFF with carry 1; SLL 8'h01 with shift 8 -> 8'h00 with carry 1.
- REQ-037 The bench SHALL check: ROL 8'h81 with shift 9 -> 8'h03, carry 0; ROR 8'h01 with shift 1 -> 8'h80.
- REQ-038 The bench SHALL check: s_clear=1 and s_valid=1 together -> m_data 16'hFFFF, m_valid=0; a following s_valid=0 -> m_data holds 16'hFFFF.
- REQ-039 The bench SHALL check, at LATENCY=3: cke=0 for 3 cycles mid-flight -> outputs frozen, then the correct results emerge in order once cke resumes.
- REQ-040 The bench SHALL check: reset asserted with 2 operations in flight -> next edge m_valid=0, m_data 16'hFFFF, and neither operation appears afterward.
